// File: rtl/rv32i_decode_stage.sv
// RV32I decode stage: field extraction, format classification, immediate generation and
// illegal detection, registered behind a valid/ready handshake with an optional skid entry.
module rv32i_decode_stage #(
  parameter int XLEN  = 32,
  parameter int SKID  = 1,
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [31:0]      in_instr_i,
  input  logic [XLEN-1:0]  in_pc_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [XLEN-1:0]  out_pc_o,
  output logic [6:0]       out_opcode_o,
  output logic [2:0]       out_funct3_o,
  output logic [6:0]       out_funct7_o,
  output logic [2:0]       out_fmt_o,
  output logic [4:0]       out_rs1_o,
  output logic [4:0]       out_rs2_o,
  output logic [4:0]       out_rd_o,
  output logic             out_rs1_en_o,
  output logic             out_rs2_en_o,
  output logic             out_rd_we_o,
  output logic [XLEN-1:0]  out_imm_o,
  output logic             out_illegal_o,
  output logic [CNT_W-1:0] decode_cnt_o,
  output logic [CNT_W-1:0] illegal_cnt_o
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYS    = 7'b1110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [2:0] FMT_R    = 3'd0;
  localparam logic [2:0] FMT_I    = 3'd1;
  localparam logic [2:0] FMT_S    = 3'd2;
  localparam logic [2:0] FMT_B    = 3'd3;
  localparam logic [2:0] FMT_U    = 3'd4;
  localparam logic [2:0] FMT_J    = 3'd5;
  localparam logic [2:0] FMT_NONE = 3'd7;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [2:0]      fmt;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic            rs1_en;
    logic            rs2_en;
    logic            rd_we;
    logic [XLEN-1:0] imm;
    logic            illegal;
  } entry_t;

  logic [6:0]         op;
  logic [6:0]         f7;
  logic [2:0]         f3;
  logic [2:0]         fmt;
  logic               sys_like;
  logic               rs1_used;
  logic               rs2_used;
  logic               rd_used;
  logic               ill;
  logic signed [31:0] imm32;
  entry_t             dec;

  assign op = in_instr_i[6:0];
  assign f3 = in_instr_i[14:12];
  assign f7 = in_instr_i[31:25];

  always_comb begin
    fmt = FMT_NONE;
    case (op)
      OP_R:                                         fmt = FMT_R;
      OP_IMM, OP_LOAD, OP_JALR, OP_SYS, OP_FENCE:   fmt = FMT_I;
      OP_STORE:                                     fmt = FMT_S;
      OP_BRANCH:                                    fmt = FMT_B;
      OP_LUI, OP_AUIPC:                             fmt = FMT_U;
      OP_JAL:                                       fmt = FMT_J;
      default:                                      fmt = FMT_NONE;
    endcase
  end

  always_comb begin
    imm32 = '0;
    case (fmt)
      FMT_I: imm32 = {{20{in_instr_i[31]}}, in_instr_i[31:20]};
      FMT_S: imm32 = {{20{in_instr_i[31]}}, in_instr_i[31:25], in_instr_i[11:7]};
      FMT_B: imm32 = {{19{in_instr_i[31]}}, in_instr_i[31], in_instr_i[7],
                      in_instr_i[30:25], in_instr_i[11:8], 1'b0};
      FMT_U: imm32 = {in_instr_i[31:12], 12'b0};
      FMT_J: imm32 = {{11{in_instr_i[31]}}, in_instr_i[31], in_instr_i[19:12],
                      in_instr_i[20], in_instr_i[30:21], 1'b0};
      default: imm32 = '0;
    endcase
  end

  always_comb begin
    ill = (in_instr_i[1:0] != 2'b11) || (fmt == FMT_NONE);
    case (op)
      OP_R:      ill = ill || ((f7 != 7'h00) && (f7 != 7'h20))
                           || ((f7 == 7'h20) && (f3 != 3'd0) && (f3 != 3'd5));
      OP_IMM:    ill = ill || ((f3 == 3'd1) && (f7 != 7'h00))
                           || ((f3 == 3'd5) && (f7 != 7'h00) && (f7 != 7'h20));
      OP_LOAD:   ill = ill || (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7);
      OP_STORE:  ill = ill || (f3 > 3'd2);
      OP_BRANCH: ill = ill || (f3 == 3'd2) || (f3 == 3'd3);
      OP_JALR:   ill = ill || (f3 != 3'd0);
      default:   ill = ill;
    endcase
  end

  // SYSTEM and FENCE are I-format but neither read rs1 nor write rd
  assign sys_like = (op == OP_SYS) || (op == OP_FENCE);
  assign rs1_used = ((fmt == FMT_R) || (fmt == FMT_I) || (fmt == FMT_S) || (fmt == FMT_B))
                    && !sys_like;
  assign rs2_used = (fmt == FMT_R) || (fmt == FMT_S) || (fmt == FMT_B);
  assign rd_used  = ((fmt == FMT_R) || (fmt == FMT_I) || (fmt == FMT_U) || (fmt == FMT_J))
                    && !sys_like;

  always_comb begin
    dec         = '0;
    dec.pc      = in_pc_i;
    dec.opcode  = op;
    dec.fmt     = fmt;
    dec.funct3  = ((fmt == FMT_R) || (fmt == FMT_I) || (fmt == FMT_S) || (fmt == FMT_B))
                  ? f3 : 3'd0;
    dec.funct7  = ((op == OP_R) || ((op == OP_IMM) && ((f3 == 3'd1) || (f3 == 3'd5))))
                  ? f7 : 7'd0;
    dec.rs1     = rs1_used ? in_instr_i[19:15] : 5'd0;
    dec.rs2     = rs2_used ? in_instr_i[24:20] : 5'd0;
    dec.rd      = rd_used  ? in_instr_i[11:7]  : 5'd0;
    dec.rs1_en  = rs1_used && !ill;
    dec.rs2_en  = rs2_used && !ill;
    dec.rd_we   = rd_used && (in_instr_i[11:7] != 5'd0) && !ill;
    dec.imm     = XLEN'(imm32);
    dec.illegal = ill;
  end

  logic             main_valid_q, main_valid_d;
  logic             skid_valid_q, skid_valid_d;
  entry_t           main_q, main_d;
  entry_t           skid_q, skid_d;
  logic [CNT_W-1:0] decode_cnt_q, decode_cnt_d;
  logic [CNT_W-1:0] illegal_cnt_q, illegal_cnt_d;
  logic             push;
  logic             pop;

  assign in_ready_o = (SKID != 0) ? !skid_valid_q : (!main_valid_q || out_ready_i);
  assign push       = in_valid_i && in_ready_o;
  assign pop        = main_valid_q && out_ready_i;

  // Skid only fills while main is stalled, so a draining main always prefers skid over input
  always_comb begin
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    main_d       = main_q;
    skid_d       = skid_q;
    if (flush_i) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (pop) begin
      if (skid_valid_q) begin
        main_d       = skid_q;
        skid_valid_d = 1'b0;
      end else if (push) begin
        main_d       = dec;
      end else begin
        main_valid_d = 1'b0;
      end
    end else if (push) begin
      if (main_valid_q) begin
        skid_d       = dec;
        skid_valid_d = 1'b1;
      end else begin
        main_d       = dec;
        main_valid_d = 1'b1;
      end
    end
  end

  always_comb begin
    decode_cnt_d  = decode_cnt_q;
    illegal_cnt_d = illegal_cnt_q;
    if (pop && (decode_cnt_q != '1)) decode_cnt_d = decode_cnt_q + CNT_W'(1);
    if (pop && main_q.illegal && (illegal_cnt_q != '1)) illegal_cnt_d = illegal_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      main_valid_q  <= 1'b0;
      skid_valid_q  <= 1'b0;
      main_q        <= '0;
      skid_q        <= '0;
      decode_cnt_q  <= '0;
      illegal_cnt_q <= '0;
    end else begin
      main_valid_q  <= main_valid_d;
      skid_valid_q  <= skid_valid_d;
      main_q        <= main_d;
      skid_q        <= skid_d;
      decode_cnt_q  <= decode_cnt_d;
      illegal_cnt_q <= illegal_cnt_d;
    end
  end

  assign out_valid_o   = main_valid_q;
  assign out_pc_o      = main_q.pc;
  assign out_opcode_o  = main_q.opcode;
  assign out_funct3_o  = main_q.funct3;
  assign out_funct7_o  = main_q.funct7;
  assign out_fmt_o     = main_q.fmt;
  assign out_rs1_o     = main_q.rs1;
  assign out_rs2_o     = main_q.rs2;
  assign out_rd_o      = main_q.rd;
  assign out_rs1_en_o  = main_q.rs1_en;
  assign out_rs2_en_o  = main_q.rs2_en;
  assign out_rd_we_o   = main_q.rd_we;
  assign out_imm_o     = main_q.imm;
  assign out_illegal_o = main_q.illegal;
  assign decode_cnt_o  = decode_cnt_q;
  assign illegal_cnt_o = illegal_cnt_q;

endmodule

// File: tb/tb_rv32i_decode_stage.sv
// Bench for rv32i_decode_stage: decode vector table, backpressure stream, flush and reset
// sequences on a SKID=1 instance, plus a SKID=0 instance with narrow saturating counters.
module tb_rv32i_decode_stage;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, flush, in_valid, out_ready;
  logic [31:0] in_instr, in_pc;
  logic        in_ready, out_valid, out_rs1_en, out_rs2_en, out_rd_we, out_illegal;
  logic [31:0] out_pc, out_imm;
  logic [6:0]  out_opcode, out_funct7;
  logic [2:0]  out_funct3, out_fmt;
  logic [4:0]  out_rs1, out_rs2, out_rd;
  logic [15:0] decode_cnt, illegal_cnt;

  logic        in_valid0, out_ready0, flush0;
  logic        in_ready0, out_valid0, out_rs1_en0, out_rs2_en0, out_rd_we0, out_illegal0;
  logic [31:0] out_pc0, out_imm0;
  logic [6:0]  out_opcode0, out_funct70;
  logic [2:0]  out_funct30, out_fmt0;
  logic [4:0]  out_rs10, out_rs20, out_rd0;
  logic [1:0]  decode_cnt0, illegal_cnt0;

  rv32i_decode_stage #(.XLEN(32), .SKID(1), .CNT_W(16)) dut (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .in_instr_i(in_instr), .in_pc_i(in_pc), .out_valid_o(out_valid), .out_ready_i(out_ready),
    .out_pc_o(out_pc), .out_opcode_o(out_opcode), .out_funct3_o(out_funct3),
    .out_funct7_o(out_funct7), .out_fmt_o(out_fmt), .out_rs1_o(out_rs1), .out_rs2_o(out_rs2),
    .out_rd_o(out_rd), .out_rs1_en_o(out_rs1_en), .out_rs2_en_o(out_rs2_en),
    .out_rd_we_o(out_rd_we), .out_imm_o(out_imm), .out_illegal_o(out_illegal),
    .decode_cnt_o(decode_cnt), .illegal_cnt_o(illegal_cnt));

  rv32i_decode_stage #(.XLEN(32), .SKID(0), .CNT_W(2)) dut0 (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush0), .in_valid_i(in_valid0), .in_ready_o(in_ready0),
    .in_instr_i(in_instr), .in_pc_i(in_pc), .out_valid_o(out_valid0), .out_ready_i(out_ready0),
    .out_pc_o(out_pc0), .out_opcode_o(out_opcode0), .out_funct3_o(out_funct30),
    .out_funct7_o(out_funct70), .out_fmt_o(out_fmt0), .out_rs1_o(out_rs10), .out_rs2_o(out_rs20),
    .out_rd_o(out_rd0), .out_rs1_en_o(out_rs1_en0), .out_rs2_en_o(out_rs2_en0),
    .out_rd_we_o(out_rd_we0), .out_imm_o(out_imm0), .out_illegal_o(out_illegal0),
    .decode_cnt_o(decode_cnt0), .illegal_cnt_o(illegal_cnt0));

  typedef struct packed {
    logic [2:0]  fmt;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        rs1_en;
    logic        rs2_en;
    logic        rd_we;
    logic        ill;
    logic [31:0] imm;
  } dec_t;

  typedef struct {
    logic [31:0] instr;
    dec_t        exp;
  } vec_t;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] addi_k(input int k);
    return (32'(k) << 20) | 32'h0000_0093;
  endfunction

  vec_t        vecs[23];
  dec_t        act;
  logic [31:0] vi;
  logic [15:0] base_dec, base_ill;
  int          exp_dec, exp_ill;
  int          sent, recv, cyc, rdy_low;

  initial begin
    //            instr          fmt  f3    f7     rs1 rs2 rd  en1 en2 we ill imm
    vecs[0]  = '{32'hFFF10093, '{3'd1,3'd0,7'h00,5'd2,5'd0,5'd1, 1,0,1,0, 32'hFFFFFFFF}};
    vecs[1]  = '{32'h00512423, '{3'd2,3'd2,7'h00,5'd2,5'd5,5'd0, 1,1,0,0, 32'h00000008}};
    vecs[2]  = '{32'hFE000EE3, '{3'd3,3'd0,7'h00,5'd0,5'd0,5'd0, 1,1,0,0, 32'hFFFFFFFC}};
    vecs[3]  = '{32'h123451B7, '{3'd4,3'd0,7'h00,5'd0,5'd0,5'd3, 0,0,1,0, 32'h12345000}};
    vecs[4]  = '{32'h00000000, '{3'd7,3'd0,7'h00,5'd0,5'd0,5'd0, 0,0,0,1, 32'h00000000}};
    vecs[5]  = '{32'h4000F0B3, '{3'd0,3'd7,7'h20,5'd1,5'd0,5'd1, 0,0,0,1, 32'h00000000}};
    vecs[6]  = '{32'h002081B3, '{3'd0,3'd0,7'h00,5'd1,5'd2,5'd3, 1,1,1,0, 32'h00000000}};
    vecs[7]  = '{32'h010000EF, '{3'd5,3'd0,7'h00,5'd0,5'd0,5'd1, 0,0,1,0, 32'h00000010}};
    vecs[8]  = '{32'h40335293, '{3'd1,3'd5,7'h20,5'd6,5'd0,5'd5, 1,0,1,0, 32'h00000403}};
    vecs[9]  = '{32'h40131093, '{3'd1,3'd1,7'h20,5'd6,5'd0,5'd1, 0,0,0,1, 32'h00000401}};
    vecs[10] = '{32'h0000B083, '{3'd1,3'd3,7'h00,5'd1,5'd0,5'd1, 0,0,0,1, 32'h00000000}};
    vecs[11] = '{32'hFFC0A103, '{3'd1,3'd2,7'h00,5'd1,5'd0,5'd2, 1,0,1,0, 32'hFFFFFFFC}};
    vecs[12] = '{32'h00000073, '{3'd1,3'd0,7'h00,5'd0,5'd0,5'd0, 0,0,0,0, 32'h00000000}};
    vecs[13] = '{32'h00009067, '{3'd1,3'd1,7'h00,5'd1,5'd0,5'd0, 0,0,0,1, 32'h00000000}};
    vecs[14] = '{32'hFFFFF517, '{3'd4,3'd0,7'h00,5'd0,5'd0,5'd10,0,0,1,0, 32'hFFFFF000}};
    vecs[15] = '{32'h00002063, '{3'd3,3'd2,7'h00,5'd0,5'd0,5'd0, 0,0,0,1, 32'h00000000}};
    vecs[16] = '{32'h00003023, '{3'd2,3'd3,7'h00,5'd0,5'd0,5'd0, 0,0,0,1, 32'h00000000}};
    vecs[17] = '{32'h00000013, '{3'd1,3'd0,7'h00,5'd0,5'd0,5'd0, 1,0,0,0, 32'h00000000}};
    vecs[18] = '{32'h401080B3, '{3'd0,3'd0,7'h20,5'd1,5'd1,5'd1, 1,1,1,0, 32'h00000000}};
    vecs[19] = '{32'h022081B3, '{3'd0,3'd0,7'h01,5'd1,5'd2,5'd3, 0,0,0,1, 32'h00000000}};
    vecs[20] = '{32'h0FF0000F, '{3'd1,3'd0,7'h00,5'd0,5'd0,5'd0, 0,0,0,0, 32'h000000FF}};
    vecs[21] = '{32'h00000011, '{3'd7,3'd0,7'h00,5'd0,5'd0,5'd0, 0,0,0,1, 32'h00000000}};
    vecs[22] = '{32'h0203D093, '{3'd1,3'd5,7'h01,5'd7,5'd0,5'd1, 0,0,0,1, 32'h00000020}};

    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    in_instr = 32'hFFF10093; in_pc = 32'h0;
    in_valid0 = 1'b0; out_ready0 = 1'b1; flush0 = 1'b0;

    // Reset held across clock edges with in_valid asserted
    repeat (3) tick();
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_decode_cnt", 64'(decode_cnt), 64'd0);
    check("rst_illegal_cnt", 64'(illegal_cnt), 64'd0);
    in_valid = 1'b0;
    rst_n = 1'b1;
    #1;
    check("rel_in_ready", 64'(in_ready), 64'd1);

    // Decode table, streamed back to back with out_ready high
    exp_dec = 0;
    exp_ill = 0;
    for (int i = 0; i < 23; i++) begin
      in_valid = 1'b1;
      in_instr = vecs[i].instr;
      in_pc    = 32'h1000 + 32'(4 * i);
      tick();
      in_valid = 1'b0;
      act = '{out_fmt, out_funct3, out_funct7, out_rs1, out_rs2, out_rd,
              out_rs1_en, out_rs2_en, out_rd_we, out_illegal, out_imm};
      vi = vecs[i].instr;
      check($sformatf("vec%0d_valid", i), 64'(out_valid), 64'd1);
      check($sformatf("vec%0d_decode", i), 64'(act), 64'(vecs[i].exp));
      check($sformatf("vec%0d_pc_op", i), {out_pc, 25'd0, out_opcode},
            {32'h1000 + 32'(4 * i), 25'd0, vi[6:0]});
      exp_dec++;
      exp_ill += int'(vecs[i].exp.ill);
    end
    tick();
    check("tbl_drained", 64'(out_valid), 64'd0);
    check("tbl_decode_cnt", 64'(decode_cnt), 64'(exp_dec));
    check("tbl_illegal_cnt", 64'(illegal_cnt), 64'(exp_ill));

    // 8-instruction stream with out_ready low for three cycles
    base_dec = decode_cnt;
    sent = 0; recv = 0; cyc = 0; rdy_low = 0;
    while (recv < 8 && cyc < 60) begin
      out_ready = !(cyc >= 3 && cyc <= 5);
      in_valid  = (sent < 8);
      in_instr  = addi_k(sent);
      in_pc     = 32'h2000 + 32'(4 * sent);
      @(negedge clk);
      if (!in_ready) rdy_low++;
      if (out_valid && out_ready) begin
        check($sformatf("strm%0d_pc", recv), 64'(out_pc), 64'(32'h2000 + 32'(4 * recv)));
        check($sformatf("strm%0d_imm", recv), 64'(out_imm), 64'(recv));
        recv++;
      end
      if (in_valid && in_ready) sent++;
      tick();
      cyc++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    check("strm_received", 64'(recv), 64'd8);
    check("strm_ready_low_cycles", 64'(rdy_low), 64'd3);
    check("strm_decode_cnt", 64'(decode_cnt - base_dec), 64'd8);
    tick();
    check("strm_no_dup", 64'(out_valid), 64'd0);

    // Flush with main and skid full while a third instruction waits
    base_dec = decode_cnt;
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = addi_k(100); in_pc = 32'h3000;
    tick();
    in_instr = addi_k(101); in_pc = 32'h3004;
    tick();
    check("fl_skid_full", {63'd0, in_ready}, 64'd0);
    in_instr = addi_k(102); in_pc = 32'h3008;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    check("fl_out_valid", 64'(out_valid), 64'd0);
    check("fl_in_ready", 64'(in_ready), 64'd1);
    check("fl_decode_cnt", 64'(decode_cnt), 64'(base_dec));
    out_ready = 1'b1;
    tick();
    check("fl_stays_empty", 64'(out_valid), 64'd0);

    // Flush coinciding with an output handshake (counted) and an input handshake (dropped)
    base_dec = decode_cnt;
    base_ill = illegal_cnt;
    in_valid = 1'b1; in_instr = 32'h00000000; in_pc = 32'h4000;
    tick();
    in_instr = addi_k(7); in_pc = 32'h4004;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    check("fl2_out_valid", 64'(out_valid), 64'd0);
    check("fl2_decode_cnt", 64'(decode_cnt), 64'(base_dec + 16'd1));
    check("fl2_illegal_cnt", 64'(illegal_cnt), 64'(base_ill + 16'd1));

    // Asynchronous reset while an entry is stalled
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = addi_k(9); in_pc = 32'h5000;
    tick();
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_out_valid", 64'(out_valid), 64'd0);
    check("arst_counters", {32'd0, decode_cnt, illegal_cnt}, 64'd0);
    tick();
    rst_n = 1'b1;
    out_ready = 1'b1;
    #1;
    check("arst_in_ready", 64'(in_ready), 64'd1);

    // SKID=0 instance: bubble-free stream and 2-bit counter saturation
    for (int k = 0; k < 6; k++) begin
      in_valid0 = 1'b1;
      in_instr  = (k < 2) ? addi_k(k + 1) : 32'h00000000;
      in_pc     = 32'h6000 + 32'(4 * k);
      tick();
      check($sformatf("s0_%0d_out", k), {30'd0, out_valid0, out_illegal0, out_imm0},
            {30'd0, 1'b1, (k >= 2), (k < 2) ? 32'(k + 1) : 32'd0});
    end
    in_valid0 = 1'b0;
    tick();
    check("s0_decode_sat", 64'(decode_cnt0), 64'd3);
    check("s0_illegal_sat", 64'(illegal_cnt0), 64'd3);
    out_ready0 = 1'b0;
    in_valid0 = 1'b1; in_instr = addi_k(5);
    tick();
    in_valid0 = 1'b0;
    check("s0_stall_ready", 64'(in_ready0), 64'd0);
    out_ready0 = 1'b1;
    #1;
    check("s0_comb_ready", 64'(in_ready0), 64'd1);
    tick();
    check("s0_drained", 64'(out_valid0), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/rv32i_decode_stage.md
Name: rv32i_decode_stage

Overview:
- Registered, parametrised front-end decode stage for RV32I. Sits between fetch and register-read/execute.
- Accepts raw instruction plus PC over a valid/ready handshake. Extracts rs1/rs2/rd and funct fields, and classifies the format for all six formats (R/I/S/B/U/J).
- Generates the fully sign-extended immediate, flags illegal encodings, and counts decoded and illegal instructions.
- A 2-entry skid buffer gives full throughput under backpressure. Synchronous flush supports branch redirect.

Parameters:
- XLEN, 32, width of PC and immediate; immediate sign-extended to XLEN.
- SKID, 1, 1 = 2-entry skid buffer (in_ready registered); 0 = single output register (in_ready = !out_valid || out_ready).
- CNT_W, 16, width of the saturating statistics counters.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset, asynchronous, active-low.
- flush  input  1  synchronous kill of all buffered entries.
- in_valid  input  1  upstream instruction valid.
- in_ready  output  1  stage can accept.
- in_instr  input  32  raw instruction bits.
- in_pc  input  XLEN  instruction PC.
- out_valid  output  1  decoded entry valid.
- out_ready  input  1  downstream accepts.
- out_pc  output  XLEN  PC of the decoded entry.
- out_opcode  output  7  instr[6:0].
- out_funct3  output  3  instr[14:12] for R/I/S/B formats, else 0.
- out_funct7  output  7  instr[31:25] for R-format and OP-IMM shifts, else 0.
- out_fmt  output  3  format code: R=0, I=1, S=2, B=3, U=4, J=5, NONE=7.
- out_rs1  output  5  source 1 index; 0 when unused.
- out_rs2  output  5  source 2 index; 0 when unused.
- out_rd  output  5  destination index; 0 when unused.
- out_rs1_en  output  1  rs1 read required.
- out_rs2_en  output  1  rs2 read required.
- out_rd_we  output  1  rd write required (rd != 0 only).
- out_imm  output  XLEN  sign-extended immediate; 0 for R-format and NONE.
- out_illegal  output  1  illegal encoding.
- decode_cnt  output  CNT_W  instructions handed downstream.
- illegal_cnt  output  CNT_W  illegal instructions handed downstream.

Behaviour:
- Reset (rst low, asynchronous): out_valid=0, all out_* data=0, counters=0, skid entries invalid. in_ready=1 in the first cycle after release.
- Handshake:
  - Transfer occurs when valid && ready on a rising edge.
  - Latency is 1 cycle: an instruction accepted at edge N is presented on out_* after edge N.
  - out_* stay stable while out_valid && !out_ready.
  - in_valid with in_ready low is not consumed; upstream holds it.
- SKID=1:
  - Main register plus one skid register. in_ready = !skid_valid (registered).
  - If out_valid && !out_ready when an input arrives, the decoded result goes to skid.
  - When the main entry drains, skid moves to main in the same edge.
  - Sustains 1 instr/cycle; no drop or duplication.
- SKID=0: in_ready combinational as stated in Parameters; bubble-free when out_ready=1.
- Format by opcode:
  - R: 0110011.
  - I: 0010011, 0000011, 1100111, 1110011, 0001111.
  - S: 0100011.
  - B: 1100011.
  - U: 0110111, 0010111.
  - J: 1101111.
  - Anything else: NONE.
- Immediates (sign bit instr[31]):
  - I: instr[31:20].
  - S: {instr[31:25], instr[11:7]}.
  - B: {instr[31], instr[7], instr[30:25], instr[11:8], 0}.
  - U: {instr[31:12], 12'b0}.
  - J: {instr[31], instr[19:12], instr[20], instr[30:21], 0}.
- Register enables:
  - rs1_en: R/I/S/B.
  - rs2_en: R/S/B.
  - rd_we: R/I/U/J with rd != 0.
  - 0110011 → R; 1110011 and 0001111 → I with rd_we=0, rs1_en=0.
- Illegal (out_illegal=1) when any of:
  - instr[1:0] != 11.
  - fmt NONE.
  - R: funct7 not 0x00/0x20, or 0x20 with funct3 not 0/5.
  - OP-IMM funct3=1 with funct7 != 0.
  - OP-IMM funct3=5 with funct7 not 0x00/0x20.
  - Load funct3 in {3,6,7}.
  - Store funct3 > 2.
  - Branch funct3 in {2,3}.
  - JALR funct3 != 0.
  - Illegal entries keep rs/rd fields as decoded but force rd_we=0, rs1_en=0, rs2_en=0.
- Counters:
  - decode_cnt increments on each out handshake.
  - illegal_cnt increments when the handshake entry has out_illegal=1.
  - Both saturate at all-ones and never wrap.
- Flush:
  - At the edge with flush=1, main and skid valids clear.
  - A simultaneous input handshake is discarded.
  - A simultaneous output handshake still counts (downstream already took it).
  - in_ready=1 in the next cycle.
- Reset mid-transfer: all entries are lost immediately; no counter update.

Test Plan:
- Reset with in_valid=1 held → out_valid=0, counters 0 during reset; in_ready=1 first cycle after release.
- Send 0xFFF10093 (addi x1,x2,-1) with out_ready=1 → next cycle fmt=1, rs1=2, rd=1, rd_we=1, imm=0xFFFFFFFF, illegal=0.
- Stream 0x00512423 (sw x5,8(x2)), 0xFE000EE3 (beq x0,x0,-4), 0x123451B7 (lui x3,0x12345) → imms 0x8, 0xFFFFFFFC, 0x12345000; fmts 2, 3, 4; rd_we 0, 0, 1.
- Stream 8 instructions, out_ready low for 3 cycles mid-stream (SKID=1) → all 8 arrive in order, none duplicated; in_ready drops only while skid full; decode_cnt=8.
- Send 0x00000000 and 0x4000F0B3 (funct7=0x20, funct3=7) → both out_illegal=1, rd_we=0; illegal_cnt=2.
- Assert flush with 2 entries buffered and in_valid=1 → out_valid=0 next cycle, 3 instructions lost, decode_cnt unchanged.
